// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU_op codes, decoded-function enum and FSM states
//               for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Main-controller ALU_op encodings
  localparam logic [1:0] c_OP_ADD   = 2'b00;
  localparam logic [1:0] c_OP_SUB   = 2'b01;
  localparam logic [1:0] c_OP_RTYPE = 2'b10;
  localparam logic [1:0] c_OP_ITYPE = 2'b11;

  typedef enum logic [3:0] {
    FN_ADD     = 4'd0,
    FN_SUB     = 4'd1,
    FN_AND     = 4'd2,
    FN_OR      = 4'd3,
    FN_XOR     = 4'd4,
    FN_SLT     = 4'd5,
    FN_SLTU    = 4'd6,
    FN_SLL     = 4'd7,
    FN_SRL     = 4'd8,
    FN_SRA     = 4'd9,
    FN_MUL     = 4'd10,
    FN_DIVU    = 4'd11,
    FN_REMU    = 4'd12,
    FN_ILLEGAL = 4'd13
  } alu_func_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_func_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_func_decode
// Description : Combinational ALU_op/funct3/funct7 to ALU function decoder.
//               M-extension encodings decode as illegal when MULDIV_EN = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_func_decode import alu_pkg::*; #(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic [1:0] ALU_op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output alu_func_t  func
);

  localparam alu_func_t c_MUL_FN  = MULDIV_EN ? FN_MUL  : FN_ILLEGAL;
  localparam alu_func_t c_DIVU_FN = MULDIV_EN ? FN_DIVU : FN_ILLEGAL;
  localparam alu_func_t c_REMU_FN = MULDIV_EN ? FN_REMU : FN_ILLEGAL;

  // Map the controller op and funct fields onto one ALU function
  always_comb begin
    func = FN_ILLEGAL;
    case (ALU_op)
      c_OP_ADD: func = FN_ADD;
      c_OP_SUB: func = FN_SUB;
      c_OP_RTYPE: begin
        case ({f7, f3})
          10'b0000000_000: func = FN_ADD;
          10'b0100000_000: func = FN_SUB;
          10'b0000000_111: func = FN_AND;
          10'b0000000_110: func = FN_OR;
          10'b0000000_100: func = FN_XOR;
          10'b0000000_010: func = FN_SLT;
          10'b0000000_011: func = FN_SLTU;
          10'b0000000_001: func = FN_SLL;
          10'b0000000_101: func = FN_SRL;
          10'b0100000_101: func = FN_SRA;
          10'b0000001_000: func = c_MUL_FN;
          10'b0000001_101: func = c_DIVU_FN;
          10'b0000001_111: func = c_REMU_FN;
          default:         func = FN_ILLEGAL;
        endcase
      end
      default: begin
        // I-type: funct7 only qualifies the shift encodings
        case (f3)
          3'b000: func = FN_ADD;
          3'b100: func = FN_XOR;
          3'b110: func = FN_OR;
          3'b111: func = FN_AND;
          3'b010: func = FN_SLT;
          3'b011: func = FN_SLTU;
          3'b001: func = (f7 == 7'b0000000) ? FN_SLL : FN_ILLEGAL;
          default: begin
            if (f7 == 7'b0000000)      func = FN_SRL;
            else if (f7 == 7'b0100000) func = FN_SRA;
            else                       func = FN_ILLEGAL;
          end
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_unit
// Description : Decoding ALU with single-cycle logic/arith ops and iterative
//               shift-add multiply and restoring unsigned divide/remainder.
//               start/done handshake; busy stalls the core while iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit import alu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      ALU_op,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int              c_SHW  = $clog2(XLEN);
  localparam int              c_CW   = c_SHW + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

  state_t            r_state, w_next;
  alu_func_t         w_func;
  logic              w_accept;
  logic [XLEN-1:0]   w_alu;
  logic [c_CW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_mul_sum;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem, r_quo, r_dvsr;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ge;
  logic              r_want_rem;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;

  alu_func_decode #(.MULDIV_EN(MULDIV_EN)) u_decode (
    .ALU_op (ALU_op),
    .f3     (f3),
    .f7     (f7),
    .func   (w_func)
  );

  // A request is only seen when no iterative op is in flight
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Single-cycle results; illegal falls through to zero
  always_comb begin
    w_alu = '0;
    case (w_func)
      FN_ADD:  w_alu = a + b;
      FN_SUB:  w_alu = a - b;
      FN_AND:  w_alu = a & b;
      FN_OR:   w_alu = a | b;
      FN_XOR:  w_alu = a ^ b;
      FN_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a < b)};
      FN_SLL:  w_alu = a << b[c_SHW-1:0];
      FN_SRL:  w_alu = a >> b[c_SHW-1:0];
      FN_SRA:  w_alu = $signed(a) >>> b[c_SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  // One multiplier bit and one quotient bit per iteration
  assign w_mul_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dvsr};
  assign w_div_ge    = ~w_div_diff[XLEN];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: dispatch on accept, leave iteration after XLEN steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_MUL, ST_DIV: begin
        if (r_cnt == c_LAST) w_next = ST_DONE;
      end
      default: begin
        if (start) begin
          if (w_func == FN_MUL)                            w_next = ST_MUL;
          else if ((w_func == FN_DIVU) || (w_func == FN_REMU)) w_next = ST_DIV;
          else                                             w_next = ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_want_rem <= 1'b0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= {{XLEN{1'b0}}, a};
      r_mplier   <= b;
      r_rem      <= '0;
      r_quo      <= a;
      r_dvsr     <= b;
      r_want_rem <= (w_func == FN_REMU);
      if ((w_func != FN_MUL) && (w_func != FN_DIVU) && (w_func != FN_REMU)) begin
        r_result  <= w_alu;
        r_illegal <= (w_func == FN_ILLEGAL);
      end
    end else if (r_state == ST_MUL) begin
      r_cnt    <= r_cnt + c_CW'(1);
      r_acc    <= w_mul_sum;
      r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
      if (r_cnt == c_LAST) begin
        r_result  <= w_mul_sum[XLEN-1:0];
        r_illegal <= 1'b0;
      end
    end else if (r_state == ST_DIV) begin
      r_cnt <= r_cnt + c_CW'(1);
      r_rem <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_div_ge};
      if (r_cnt == c_LAST) begin
        r_result  <= r_want_rem ? (w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0])
                                : {r_quo[XLEN-2:0], w_div_ge};
        r_illegal <= 1'b0;
      end
    end
  end

  assign busy    = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign done    = (r_state == ST_DONE);
  assign result  = r_result;
  assign zero    = (r_result == '0);
  assign illegal = r_illegal;

endmodule
`default_nettype wire
